// File: rtl/irq_pkg.sv
// Shared types and limits for the command-FIFO IRQ drain path.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE_ST  = 2'd0,
    FETCH_ST = 2'd1,
    OUT_ST   = 2'd2
  } drainer_fsm_t;

  localparam logic [15:0] SPURIOUS_MAX = 16'hFFFF;

endpackage

// File: rtl/irq_event_cmd_drainer_if.sv
// Command FIFO read side plus AXI-Stream output, bundled for the drainer.
interface irq_event_cmd_drainer_if #(
  parameter int DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0] CMD_DIN;
  logic                  CMD_EMPTY;
  logic                  CMD_RDEN;
  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TREADY;

  // master = drainer: pops the FIFO and drives the stream
  modport master (
    input  CMD_DIN, CMD_EMPTY, M_AXIS_TREADY,
    output CMD_RDEN, M_AXIS_TDATA, M_AXIS_TVALID
  );

  modport slave (
    output CMD_DIN, CMD_EMPTY, M_AXIS_TREADY,
    input  CMD_RDEN, M_AXIS_TDATA, M_AXIS_TVALID
  );

endinterface

// File: rtl/irq_edge_detect.sv
// Registered rising-edge detector for IRQ impulses; RISE is high for the
// first cycle IN is seen high.
module irq_edge_detect (
  input  logic CLK,
  input  logic RESETN,
  input  logic IN,
  output logic RISE
);

  logic d_irq;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) d_irq <= 1'b0;
    else         d_irq <= IN;
  end

  assign RISE = IN & ~d_irq;

endmodule

// File: rtl/irq_event_cmd_drainer.sv
// Drains the FWFT command FIFO onto an AXI-Stream master after each IRQ
// event, acknowledging when empty and counting transfers / spurious IRQs.
module irq_event_cmd_drainer
  import irq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 16
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic                          IRQ_IN,
  irq_event_cmd_drainer_if.master       bus,
  output logic                          IRQ_ACK,
  output logic [31:0]                   EVENT_CNT,
  output logic [15:0]                   SPURIOUS_CNT
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == SPURIOUS_MAX) ? v : v + 16'd1;
  endfunction

  drainer_fsm_t          state_q;
  logic [WAIT_W-1:0]     wait_q;
  logic                  pending_q;
  logic [DATA_WIDTH-1:0] tdata_p1;
  logic                  vld_p1;
  logic                  ack_q;
  logic [31:0]           event_q;
  logic [15:0]           spur_q;
  logic                  irq_edge;

  irq_edge_detect u_edge (
    .CLK    (CLK),
    .RESETN (RESETN),
    .IN     (IRQ_IN),
    .RISE   (irq_edge)
  );

  // Pop is combinational so the FWFT head is captured on the same edge.
  assign bus.CMD_RDEN      = (state_q == FETCH_ST) & ~bus.CMD_EMPTY;
  assign bus.M_AXIS_TDATA  = tdata_p1;
  assign bus.M_AXIS_TVALID = vld_p1;
  assign IRQ_ACK           = ack_q;
  assign EVENT_CNT         = event_q;
  assign SPURIOUS_CNT      = spur_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= IDLE_ST;
      wait_q    <= '0;
      pending_q <= 1'b0;
      tdata_p1  <= '0;
      vld_p1    <= 1'b0;
      ack_q     <= 1'b0;
      event_q   <= '0;
      spur_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      if (irq_edge) pending_q <= 1'b1;
      // Every entry into IDLE_ST drops pending unless a fresh edge arrives now.
      case (state_q)
        IDLE_ST: begin
          if (irq_edge | pending_q) begin
            state_q <= FETCH_ST;
            wait_q  <= '0;
          end
        end
        FETCH_ST: begin
          if (!bus.CMD_EMPTY) begin
            tdata_p1 <= bus.CMD_DIN;
            vld_p1   <= 1'b1;
            state_q  <= OUT_ST;
          end else if (wait_q == WAIT_LAST) begin
            spur_q    <= sat_inc(spur_q);
            state_q   <= IDLE_ST;
            pending_q <= irq_edge;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        OUT_ST: begin
          if (bus.M_AXIS_TREADY) begin
            event_q <= event_q + 32'd1;
            vld_p1  <= 1'b0;
            if (!bus.CMD_EMPTY) begin
              state_q <= FETCH_ST;
              wait_q  <= '0;
            end else begin
              state_q   <= IDLE_ST;
              ack_q     <= 1'b1;
              pending_q <= irq_edge;
            end
          end
        end
        default: begin
          state_q   <= IDLE_ST;
          vld_p1    <= 1'b0;
          pending_q <= irq_edge;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_event_cmd_drainer.sv
// Directed + randomized bench for irq_event_cmd_drainer with a queue-based
// FIFO/scoreboard reference.
module tb_irq_event_cmd_drainer;

  localparam int DW = 64;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        IRQ_IN = 1'b0;
  logic        IRQ_ACK;
  logic [31:0] EVENT_CNT;
  logic [15:0] SPURIOUS_CNT;

  irq_event_cmd_drainer_if #(.DATA_WIDTH(DW)) bus ();

  irq_event_cmd_drainer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .IRQ_IN       (IRQ_IN),
    .bus          (bus.master),
    .IRQ_ACK      (IRQ_ACK),
    .EVENT_CNT    (EVENT_CNT),
    .SPURIOUS_CNT (SPURIOUS_CNT)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] fifo[$];
  logic [63:0] sb[$];
  int          ack_seen = 0;
  int          rd_cnt = 0;
  logic [31:0] exp_evt = '0;
  logic [15:0] exp_spur = '0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifo();
    bus.CMD_EMPTY = (fifo.size() == 0);
    bus.CMD_DIN   = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic push(input logic [63:0] v);
    fifo.push_back(v);
    sb.push_back(v);
    drive_fifo();
  endtask

  // One clock: observe pre-edge handshake/pop, then update the FIFO model.
  task automatic cycle();
    logic rd;
    logic hs;
    rd = bus.CMD_RDEN;
    if (rd) chk("rden_while_empty", bus.CMD_EMPTY, 1'b0);
    if (prev_stall) begin
      chk("tvalid_hold", bus.M_AXIS_TVALID, 1'b1);
      chk("tdata_hold", bus.M_AXIS_TDATA, prev_data);
    end
    hs = bus.M_AXIS_TVALID & bus.M_AXIS_TREADY;
    if (hs) begin
      chk("unexpected_transfer", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("tdata_order", bus.M_AXIS_TDATA, sb.pop_front());
      exp_evt = exp_evt + 32'd1;
    end
    prev_stall = bus.M_AXIS_TVALID & ~bus.M_AXIS_TREADY;
    prev_data  = bus.M_AXIS_TDATA;
    @(posedge CLK);
    #1;
    if (rd) begin
      rd_cnt++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    drive_fifo();
    if (IRQ_ACK) ack_seen++;
    @(negedge CLK);
  endtask

  task automatic spur_model_inc();
    int s;
    s = int'(exp_spur) + 1;
    exp_spur = (s > 65535) ? 16'hFFFF : 16'(s);
  endtask

  initial begin
    logic [63:0] w[4];
    int ack0, rd0, n, hold, extra;
    logic [15:0] spur0;

    bus.M_AXIS_TREADY = 1'b1;
    drive_fifo();
    repeat (2) @(negedge CLK);
    chk("rst_tvalid", bus.M_AXIS_TVALID, 1'b0);
    chk("rst_tdata", bus.M_AXIS_TDATA, 64'd0);
    chk("rst_ack", IRQ_ACK, 1'b0);
    chk("rst_rden", bus.CMD_RDEN, 1'b0);
    chk("rst_evt", EVENT_CNT, 32'd0);
    chk("rst_spur", SPURIOUS_CNT, 16'd0);
    RESETN = 1'b1;
    repeat (2) cycle();

    // Three preloaded words, single IRQ impulse: words at +2,+4,+6, ack at +7.
    w[0] = 64'hA0A0_0000_1111_0001;
    w[1] = 64'hB0B0_0000_2222_0002;
    w[2] = 64'hC0C0_0000_3333_0003;
    for (int i = 0; i < 3; i++) push(w[i]);
    ack0 = ack_seen; rd0 = rd_cnt;
    IRQ_IN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      IRQ_IN = 1'b0;
      chk($sformatf("t1_tvalid_c%0d", i), bus.M_AXIS_TVALID, (i == 2 || i == 4 || i == 6));
      if (i == 2 || i == 4 || i == 6) chk($sformatf("t1_tdata_c%0d", i), bus.M_AXIS_TDATA, w[i/2-1]);
      chk($sformatf("t1_ack_c%0d", i), IRQ_ACK, (i == 7));
    end
    chk("t1_evt", EVENT_CNT, 32'd3);
    chk("t1_rden_cnt", rd_cnt - rd0, 3);
    chk("t1_ack_cnt", ack_seen - ack0, 1);
    chk("t1_sb_empty", sb.size(), 0);

    // Empty FIFO: spurious after 16 FETCH cycles, no pop, no ack.
    ack0 = ack_seen; rd0 = rd_cnt; spur0 = exp_spur;
    IRQ_IN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      IRQ_IN = 1'b0;
      if (i == 16 || i == 17 || i == 20)
        chk($sformatf("t2_spur_c%0d", i), SPURIOUS_CNT, (i >= 17) ? spur0 + 16'd1 : spur0);
    end
    spur_model_inc();
    chk("t2_rden_cnt", rd_cnt - rd0, 0);
    chk("t2_ack_cnt", ack_seen - ack0, 0);

    // Back-pressure: one word held stable while TREADY is low.
    w[3] = 64'hD00D_FEED_0000_0004;
    push(w[3]);
    bus.M_AXIS_TREADY = 1'b0;
    IRQ_IN = 1'b1;
    cycle();
    IRQ_IN = 1'b0;
    for (int i = 2; i <= 11; i++) begin
      cycle();
      chk($sformatf("t3_tvalid_c%0d", i), bus.M_AXIS_TVALID, 1'b1);
      chk($sformatf("t3_tdata_c%0d", i), bus.M_AXIS_TDATA, w[3]);
      chk($sformatf("t3_evt_c%0d", i), EVENT_CNT, 32'd3);
    end
    bus.M_AXIS_TREADY = 1'b1;
    cycle();
    chk("t3_evt_after", EVENT_CNT, 32'd4);
    chk("t3_tvalid_after", bus.M_AXIS_TVALID, 1'b0);
    chk("t3_ack", IRQ_ACK, 1'b1);

    // IRQ edges every two cycles during a 4-word drain are absorbed.
    ack0 = ack_seen; spur0 = exp_spur;
    for (int i = 0; i < 4; i++) push(64'($urandom) << 32 | 64'($urandom));
    for (int i = 1; i <= 35; i++) begin
      IRQ_IN = (i <= 8) && (i % 2 == 1);
      cycle();
    end
    IRQ_IN = 1'b0;
    chk("t4_evt", EVENT_CNT, exp_evt);
    chk("t4_evt_abs", EVENT_CNT, 32'd8);
    chk("t4_ack_cnt", ack_seen - ack0, 1);
    chk("t4_spur", SPURIOUS_CNT, spur0);
    chk("t4_sb_empty", sb.size(), 0);

    // Edge landing in the IDLE-entry cycle starts a new (here spurious) fetch.
    ack0 = ack_seen; spur0 = exp_spur;
    push(64'h1D1E_0000_0000_0005);
    for (int i = 1; i <= 25; i++) begin
      IRQ_IN = (i == 1) || (i == 3);
      cycle();
    end
    IRQ_IN = 1'b0;
    spur_model_inc();
    chk("t4b_ack_cnt", ack_seen - ack0, 1);
    chk("t4b_spur", SPURIOUS_CNT, exp_spur);
    chk("t4b_evt", EVENT_CNT, exp_evt);

    // Asynchronous reset while a word is being offered.
    push(64'hE0E0_E0E0_0000_0006);
    bus.M_AXIS_TREADY = 1'b0;
    IRQ_IN = 1'b1;
    cycle();
    IRQ_IN = 1'b0;
    repeat (2) cycle();
    chk("t5_tvalid_pre", bus.M_AXIS_TVALID, 1'b1);
    #2 RESETN = 1'b0;
    #1;
    chk("t5_tvalid_async", bus.M_AXIS_TVALID, 1'b0);
    chk("t5_ack_async", IRQ_ACK, 1'b0);
    chk("t5_rden_async", bus.CMD_RDEN, 1'b0);
    chk("t5_evt_async", EVENT_CNT, 32'd0);
    chk("t5_spur_async", SPURIOUS_CNT, 16'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    sb.delete();
    fifo.delete();
    drive_fifo();
    exp_evt = '0; exp_spur = '0; prev_stall = 1'b0;
    bus.M_AXIS_TREADY = 1'b1;
    ack0 = ack_seen;
    push(64'hF00F_0000_0000_0007);
    IRQ_IN = 1'b1;
    cycle();
    IRQ_IN = 1'b0;
    repeat (9) cycle();
    chk("t5_evt_restart", EVENT_CNT, 32'd1);
    chk("t5_ack_restart", ack_seen - ack0, 1);
    chk("t5_sb_empty", sb.size(), 0);

    // Saturation of SPURIOUS_CNT and wrap of EVENT_CNT.
    force dut.spur_q = 16'hFFFE;
    @(posedge CLK);
    #1 release dut.spur_q;
    @(negedge CLK);
    exp_spur = 16'hFFFE;
    chk("t6_spur_preset", SPURIOUS_CNT, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      IRQ_IN = 1'b1;
      cycle();
      IRQ_IN = 1'b0;
      repeat (20) cycle();
      spur_model_inc();
      chk($sformatf("t6_spur_r%0d", k), SPURIOUS_CNT, exp_spur);
    end
    chk("t6_spur_sat", SPURIOUS_CNT, 16'hFFFF);
    force dut.event_q = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1 release dut.event_q;
    @(negedge CLK);
    exp_evt = 32'hFFFF_FFFF;
    push(64'h0123_4567_89AB_CDEF);
    IRQ_IN = 1'b1;
    cycle();
    IRQ_IN = 1'b0;
    repeat (9) cycle();
    chk("t6_evt_wrap", EVENT_CNT, exp_evt);
    chk("t6_evt_zero", EVENT_CNT, 32'd0);

    // Randomized drains: random length, TREADY, held/pulsed IRQ, late pushes.
    for (int r = 0; r < 4; r++) begin
      ack0 = ack_seen; spur0 = exp_spur;
      n = $urandom_range(1, 6);
      hold = $urandom_range(0, 1);
      extra = 0;
      for (int i = 0; i < n; i++) push(64'($urandom) << 32 | 64'($urandom));
      IRQ_IN = 1'b1;
      for (int c = 0; c < 300 && ack_seen == ack0; c++) begin
        bus.M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
        if (c > 0 && hold == 0) IRQ_IN = 1'b0;
        if (fifo.size() != 0 && extra < 4 && $urandom_range(0, 7) == 0) begin
          push(64'($urandom) << 32 | 64'($urandom));
          extra++;
        end
        cycle();
      end
      IRQ_IN = 1'b0;
      bus.M_AXIS_TREADY = 1'b1;
      repeat (4) cycle();
      chk($sformatf("rnd%0d_ack_cnt", r), ack_seen - ack0, 1);
      chk($sformatf("rnd%0d_sb_empty", r), sb.size(), 0);
      chk($sformatf("rnd%0d_evt", r), EVENT_CNT, exp_evt);
      chk($sformatf("rnd%0d_spur", r), SPURIOUS_CNT, spur0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
